// File: rtl/digit_vision_pkg.sv
// Shared constants and FSM state type for the digit-recognition video path.
package digit_vision_pkg;
  localparam int H_ACT      = 640;
  localparam int V_ACT      = 480;
  localparam int COORD_W    = 11;
  localparam int PIX_W      = 10;
  localparam int LUMA_SUM_W = 12;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    PUBLISH  = 2'd2
  } bbox_state_e;
endpackage

// File: rtl/rgb_luma.sv
// Registered luma approximation (R + 2G + B) / 4 with the pixel's X/Y/strobe
// delayed by the same single stage so downstream logic sees them aligned.
module rgb_luma import digit_vision_pkg::*; (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [PIX_W-1:0]   iRed,
  input  logic [PIX_W-1:0]   iGreen,
  input  logic [PIX_W-1:0]   iBlue,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  output logic [PIX_W-1:0]   oLuma,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oDVAL
);
  logic [LUMA_SUM_W-1:0] sum_s;
  logic [PIX_W-1:0]      luma_q;
  logic [COORD_W-1:0]    x_q;
  logic [COORD_W-1:0]    y_q;
  logic                  dval_q;

  assign sum_s = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};

  // Stage-1 pipeline register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      luma_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      dval_q <= 1'b0;
    end else begin
      luma_q <= sum_s[LUMA_SUM_W-1:2];
      x_q    <= iX;
      y_q    <= iY;
      dval_q <= iDVAL;
    end
  end

  assign oLuma = luma_q;
  assign oX    = x_q;
  assign oY    = y_q;
  assign oDVAL = dval_q;
endmodule

// File: rtl/digit_bbox_extract.sv
// Per-frame bounding box and ink-pixel count of dark pixels in a VGA-timed RGB
// stream; publishes one registered result with a single-cycle valid pulse.
module digit_bbox_extract import digit_vision_pkg::*; #(
  parameter int MIN_PIXELS = 64,
  parameter int CNT_W      = 19
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [PIX_W-1:0]   iRed,
  input  logic [PIX_W-1:0]   iGreen,
  input  logic [PIX_W-1:0]   iBlue,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  input  logic [PIX_W-1:0]   iThresh,
  output logic [COORD_W-1:0] oMinX,
  output logic [COORD_W-1:0] oMaxX,
  output logic [COORD_W-1:0] oMinY,
  output logic [COORD_W-1:0] oMaxY,
  output logic [CNT_W-1:0]   oCount,
  output logic               oFound,
  output logic               oBoxValid
);
  logic [PIX_W-1:0]   luma1_s;
  logic [COORD_W-1:0] x1_s, y1_s;
  logic               dval1_s;

  rgb_luma u_luma (
    .iCLK  (iCLK),   .iRST_N(iRST_N),
    .iRed  (iRed),   .iGreen(iGreen), .iBlue(iBlue),
    .iDVAL (iDVAL),  .iX    (iX),     .iY   (iY),
    .oLuma (luma1_s), .oX   (x1_s),   .oY   (y1_s), .oDVAL(dval1_s)
  );

  bbox_state_e        state_q;
  logic [COORD_W-1:0] minx_q, maxx_q, miny_q, maxy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] minx_d, maxx_d, miny_d, maxy_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [COORD_W-1:0] base_minx_s, base_maxx_s, base_miny_s, base_maxy_s;
  logic [CNT_W-1:0]   base_cnt_s;
  logic pix_ok_s, sof_s, eof_s, dark_s, take_s, restart_s, acc_en_s;
  logic [COORD_W-1:0] out_minx_q, out_maxx_q, out_miny_q, out_maxy_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic               out_found_q, out_valid_q;

  assign pix_ok_s  = dval1_s && (x1_s < COORD_W'(H_ACT)) && (y1_s < COORD_W'(V_ACT));
  assign sof_s     = pix_ok_s && (x1_s == '0) && (y1_s == '0);
  assign eof_s     = pix_ok_s && (x1_s == COORD_W'(H_ACT - 1)) && (y1_s == COORD_W'(V_ACT - 1));
  assign dark_s    = pix_ok_s && (luma1_s < iThresh);
  // Only in-frame pixels count; a frame start seen in either state reopens the frame.
  assign take_s    = pix_ok_s && ((state_q == ACCUM) || ((state_q == WAIT_SOF) && sof_s));
  assign restart_s = take_s && sof_s;
  assign acc_en_s  = take_s && dark_s;

  assign base_minx_s = restart_s ? {COORD_W{1'b1}} : minx_q;
  assign base_maxx_s = restart_s ? {COORD_W{1'b0}} : maxx_q;
  assign base_miny_s = restart_s ? {COORD_W{1'b1}} : miny_q;
  assign base_maxy_s = restart_s ? {COORD_W{1'b0}} : maxy_q;
  assign base_cnt_s  = restart_s ? {CNT_W{1'b0}}   : cnt_q;

  assign minx_d = (acc_en_s && (x1_s < base_minx_s)) ? x1_s : base_minx_s;
  assign maxx_d = (acc_en_s && (x1_s > base_maxx_s)) ? x1_s : base_maxx_s;
  assign miny_d = (acc_en_s && (y1_s < base_miny_s)) ? y1_s : base_miny_s;
  assign maxy_d = (acc_en_s && (y1_s > base_maxy_s)) ? y1_s : base_maxy_s;
  assign cnt_d  = (acc_en_s && (base_cnt_s != {CNT_W{1'b1}})) ? base_cnt_s + CNT_W'(1) : base_cnt_s;

  // Frame FSM, accumulators and registered result.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= WAIT_SOF;
      minx_q      <= {COORD_W{1'b1}};
      maxx_q      <= {COORD_W{1'b0}};
      miny_q      <= {COORD_W{1'b1}};
      maxy_q      <= {COORD_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_minx_q  <= '0;
      out_maxx_q  <= '0;
      out_miny_q  <= '0;
      out_maxy_q  <= '0;
      out_cnt_q   <= '0;
      out_found_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        WAIT_SOF, ACCUM: begin
          minx_q <= minx_d;
          maxx_q <= maxx_d;
          miny_q <= miny_d;
          maxy_q <= maxy_d;
          cnt_q  <= cnt_d;
          if (take_s && eof_s && (state_q == ACCUM)) begin
            state_q <= PUBLISH;
          end else if (take_s) begin
            state_q <= ACCUM;
          end else begin
            state_q <= state_q;
          end
        end
        PUBLISH: begin
          // An empty frame publishes zeros rather than the raw reset-value minima.
          if (cnt_q == '0) begin
            out_minx_q <= '0;
            out_maxx_q <= '0;
            out_miny_q <= '0;
            out_maxy_q <= '0;
          end else begin
            out_minx_q <= minx_q;
            out_maxx_q <= maxx_q;
            out_miny_q <= miny_q;
            out_maxy_q <= maxy_q;
          end
          out_cnt_q   <= cnt_q;
          out_found_q <= (cnt_q >= CNT_W'(MIN_PIXELS));
          out_valid_q <= 1'b1;
          minx_q      <= {COORD_W{1'b1}};
          maxx_q      <= {COORD_W{1'b0}};
          miny_q      <= {COORD_W{1'b1}};
          maxy_q      <= {COORD_W{1'b0}};
          cnt_q       <= {CNT_W{1'b0}};
          state_q     <= WAIT_SOF;
        end
        default: begin
          state_q <= WAIT_SOF;
        end
      endcase
    end
  end

  assign oMinX     = out_minx_q;
  assign oMaxX     = out_maxx_q;
  assign oMinY     = out_miny_q;
  assign oMaxY     = out_maxy_q;
  assign oCount    = out_cnt_q;
  assign oFound    = out_found_q;
  assign oBoxValid = out_valid_q;
endmodule

// File: tb/tb_digit_bbox_extract.sv
// Self-checking bench: directed and randomized pixel streams compared against a
// frame-level reference model of the bounding-box result and publish timing.
module tb_digit_bbox_extract;
  import digit_vision_pkg::*;

  logic               iCLK;
  logic               iRST_N;
  logic [PIX_W-1:0]   iRed, iGreen, iBlue, iThresh;
  logic               iDVAL;
  logic [COORD_W-1:0] iX, iY;
  logic [COORD_W-1:0] oMinX, oMaxX, oMinY, oMaxY;
  logic [18:0]        oCount;
  logic               oFound, oBoxValid;

  digit_bbox_extract #(.MIN_PIXELS(64), .CNT_W(19)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDVAL(iDVAL), .iX(iX), .iY(iY), .iThresh(iThresh),
    .oMinX(oMinX), .oMaxX(oMaxX), .oMinY(oMinY), .oMaxY(oMaxY),
    .oCount(oCount), .oFound(oFound), .oBoxValid(oBoxValid)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    int minx; int maxx; int miny; int maxy; int cnt; int found; int cyc;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  res_t last_exp;
  res_t mon_r;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   gaps_en = 1'b0;

  // Reference model state: whether a frame is open and its running statistics.
  bit m_in = 1'b0;
  int m_minx, m_maxx, m_miny, m_maxy, m_cnt;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) begin
    if (iRST_N === 1'b1 && oBoxValid === 1'b1) begin
      mon_r.minx = int'(oMinX); mon_r.maxx = int'(oMaxX);
      mon_r.miny = int'(oMinY); mon_r.maxy = int'(oMaxY);
      mon_r.cnt = int'(oCount); mon_r.found = int'(oFound); mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iCLK);
      iDVAL = 1'b0;
      iX = COORD_W'($urandom_range(0, 700));
      iY = COORD_W'($urandom_range(0, 500));
      iRed = '0; iGreen = '0; iBlue = '0;
    end
  endtask

  task automatic put(input int x, input int y, input int r, input int g, input int b);
    int  luma;
    res_t e;
    if (gaps_en && ($urandom_range(0, 1) == 1)) idle(1);
    @(negedge iCLK);
    iDVAL = 1'b1; iX = COORD_W'(x); iY = COORD_W'(y);
    iRed = PIX_W'(r); iGreen = PIX_W'(g); iBlue = PIX_W'(b);
    luma = (r + 2 * g + b) / 4;
    if (x < H_ACT && y < V_ACT) begin
      if (x == 0 && y == 0) begin
        m_in = 1'b1; m_cnt = 0;
        m_minx = 9999; m_maxx = -1; m_miny = 9999; m_maxy = -1;
      end
      if (m_in && luma < int'(iThresh)) begin
        m_cnt++;
        if (x < m_minx) m_minx = x;
        if (x > m_maxx) m_maxx = x;
        if (y < m_miny) m_miny = y;
        if (y > m_maxy) m_maxy = y;
      end
      if (m_in && x == H_ACT - 1 && y == V_ACT - 1) begin
        e.minx = (m_cnt == 0) ? 0 : m_minx; e.maxx = (m_cnt == 0) ? 0 : m_maxx;
        e.miny = (m_cnt == 0) ? 0 : m_miny; e.maxy = (m_cnt == 0) ? 0 : m_maxy;
        e.cnt = m_cnt; e.found = (m_cnt >= 64) ? 1 : 0; e.cyc = cyc + 3;
        exp_q.push_back(e);
        m_in = 1'b0;
      end
    end
  endtask

  task automatic put_lvl(input int x, input int y, input int lvl);
    put(x, y, lvl, lvl, lvl);
  endtask

  // Window frame: rnd=0 draws a black rectangle on white, rnd=1 paints random colours.
  task automatic frame_win(input int x0, input int x1, input int y0, input int y1,
                           input bit rnd, input bit junk);
    if (rnd) put(0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    else     put_lvl(0, 0, 1023);
    for (int y = y0 - 4; y <= y1 + 4; y++) begin
      for (int x = x0 - 4; x <= x1 + 4; x++) begin
        if (rnd) put(x, y, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
        else     put_lvl(x, y, (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? 0 : 1023);
      end
      if (junk) put_lvl(700, y, 0);
    end
    if (rnd) put(639, 479, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    else     put_lvl(639, 479, 1023);
    idle(6);
  endtask

  // Sparse uniform frame touching all four borders.
  task automatic frame_grid(input int lvl);
    for (int j = 0; j <= 30; j++) begin
      for (int i = 0; i <= 40; i++) begin
        put_lvl((i == 40) ? 639 : i * 16, (j == 30) ? 479 : j * 16, lvl);
      end
    end
    idle(6);
  endtask

  task automatic check_results(input string tag);
    res_t o, e;
    chk({tag, "_npulse"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_minx"}, o.minx, e.minx);
      chk({tag, "_maxx"}, o.maxx, e.maxx);
      chk({tag, "_miny"}, o.miny, e.miny);
      chk({tag, "_maxy"}, o.maxy, e.maxy);
      chk({tag, "_count"}, o.cnt, e.cnt);
      chk({tag, "_found"}, o.found, e.found);
      chk({tag, "_latency"}, o.cyc, e.cyc);
      last_exp = e;
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_hold_minx"}, 32'(oMinX), last_exp.minx);
    chk({tag, "_hold_maxx"}, 32'(oMaxX), last_exp.maxx);
    chk({tag, "_hold_miny"}, 32'(oMinY), last_exp.miny);
    chk({tag, "_hold_maxy"}, 32'(oMaxY), last_exp.maxy);
    chk({tag, "_hold_count"}, 32'(oCount), last_exp.cnt);
    chk({tag, "_hold_found"}, 32'(oFound), last_exp.found);
    chk({tag, "_valid_low"}, 32'(oBoxValid), 0);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    m_in = 1'b0;
    last_exp = '{0, 0, 0, 0, 0, 0, 0};
    idle(3);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  initial begin
    int rx0, ry0;
    iRST_N = 1'b1; iDVAL = 1'b0; iX = '0; iY = '0;
    iRed = '0; iGreen = '0; iBlue = '0; iThresh = 10'd512;
    do_reset();
    idle(2);
    check_results("reset");

    frame_win(200, 263, 100, 163, 1'b0, 1'b0);
    check_results("rect");

    gaps_en = 1'b1;
    frame_win(200, 263, 100, 163, 1'b0, 1'b1);
    gaps_en = 1'b0;
    check_results("rect_gaps");

    put_lvl(0, 0, 0);
    for (int x = 1; x < 30; x++) put_lvl(x, 0, 0);
    do_reset();
    idle(2);
    check_results("midreset");
    frame_grid(1023);
    check_results("white");

    put_lvl(0, 0, 1023);
    put_lvl(320, 240, 1023);
    put_lvl(639, 479, 0);
    idle(6);
    check_results("single");

    for (int y = 240; y < 244; y++)
      for (int x = 100; x <= 200; x++) put_lvl(x, y, 0);
    put_lvl(639, 479, 0);
    idle(6);
    check_results("midstart");
    frame_win(200, 263, 100, 163, 1'b0, 1'b0);
    check_results("after_sync");

    iThresh = 10'd400;
    frame_grid(400);
    check_results("gray400");
    iThresh = 10'd401;
    frame_grid(400);
    check_results("gray401");

    for (int k = 0; k < 2; k++) begin
      rx0 = $urandom_range(8, 560);
      ry0 = $urandom_range(8, 400);
      idle(1);
      iThresh = PIX_W'($urandom_range(100, 900));
      gaps_en = 1'b1;
      frame_win(rx0, rx0 + $urandom_range(8, 55), ry0, ry0 + $urandom_range(8, 55), 1'b1, 1'b1);
      gaps_en = 1'b0;
      check_results($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
